// File: rtl/desc_sort_emitter.sv
// desc_sort_emitter: buffers a burst of samples in a descending sorted list and emits it largest-first
module desc_sort_emitter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] e_q [DEPTH];
    logic [DATA_WIDTH-1:0] e_d [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic [DEPTH-1:0]      ge;
    logic                  acc, pop;

    // Handshake flags come from registered state only; reset just masks them.
    assign in_ready  = resetn & (state_q == FILL);
    assign out_valid = resetn & (state_q == DRAIN);
    assign out_data  = e_q[0];
    assign out_last  = out_valid & (count_q == CW'(1));
    assign count     = count_q;
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Sorted insert on accept (ties land after equal values), head pop on drain handshake.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        e_d     = e_q;
        ge      = '0;
        if (acc) begin
            for (int i = 0; i < DEPTH; i++)
                ge[i] = (CW'(i) < count_q) && (e_q[i] >= in_data);
            e_d[0] = ge[0] ? e_q[0] : in_data;
            for (int i = 1; i < DEPTH; i++)
                e_d[i] = ge[i] ? e_q[i] : (ge[i-1] ? in_data : e_q[i-1]);
            count_d = count_q + CW'(1);
            if (in_last || count_q == CW'(DEPTH-1))
                state_d = DRAIN;
        end
        if (pop) begin
            for (int i = 0; i < DEPTH-1; i++)
                e_d[i] = e_q[i+1];
            e_d[DEPTH-1] = '0;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1))
                state_d = FILL;
        end
    end

    // State, storage and occupancy registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= FILL;
            count_q <= '0;
            e_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            e_q     <= e_d;
        end
    end
endmodule

// File: tb/tb_desc_sort_emitter.sv
// tb_desc_sort_emitter: directed bursts with a scoreboard-driven output monitor
module tb_desc_sort_emitter;
    logic        clk = 0;
    logic        resetn = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = 0;
    logic        in_last = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [31:0] out_data;
    logic        out_last;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];

    desc_sort_emitter #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output beat is compared against the scoreboard head.
    always @(negedge clk) begin
        if (resetn && out_valid) begin
            chk("drain_in_ready", 32'(in_ready), 32'd0);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", out_data, 32'hDEAD_BEEF);
                end else begin
                    logic [32:0] x;
                    x = sb.pop_front();
                    chk("out_data", out_data, x[31:0]);
                    chk("out_last", 32'(out_last), 32'(x[32]));
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input int k);
        int n;
        n = 0;
        in_valid = 1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 0;
        in_last  = 0;
        chk("fill_count", 32'(count), 32'(k));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end else begin
            @(posedge clk); #1;
            chk("turnaround_in_ready", 32'(in_ready), 32'd1);
            chk("end_count", 32'(count), 32'd0);
            chk("end_out_valid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic burst(input logic [31:0] din[$], input logic [31:0] exp[$], input bit use_last, input int hold);
        foreach (exp[i]) sb.push_back({(i == exp.size() - 1), exp[i]});
        if (hold > 0) out_ready = 0;
        foreach (din[i]) send(din[i], use_last && (i == din.size() - 1), i + 1);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk); #1;
                chk("bp_valid", 32'(out_valid), 32'd1);
                chk("bp_data", out_data, exp[0]);
                chk("bp_last", 32'(out_last), 32'd0);
            end
            @(posedge clk); #1;
            out_ready = 1;
        end
        wait_drain();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        resetn = 1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        burst('{5, 9, 2, 7}, '{9, 7, 5, 2}, 1, 0);
        burst('{3, 1, 4, 1}, '{4, 3, 1, 1}, 0, 0);
        burst('{0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF}, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0}, 1, 0);
        burst('{10, 20}, '{20, 10}, 1, 3);
        burst('{42}, '{42}, 1, 0);

        sb.push_back({1'b0, 32'd9});
        sb.push_back({1'b0, 32'd7});
        sb.push_back({1'b1, 32'd5});
        send(9, 0, 1);
        send(7, 0, 2);
        send(5, 1, 3);
        n = 0;
        while (sb.size() > 2 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_drain_pos", 32'(sb.size()), 32'd2);
        @(posedge clk); #1;
        resetn = 0;
        sb.delete();
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        resetn = 1;
        @(posedge clk); #1;
        chk("mid_rst_release_ready", 32'(in_ready), 32'd1);
        burst('{1, 2}, '{2, 1}, 1, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/desc_sort_emitter.md
# desc_sort_emitter

Buffers a burst of up to DEPTH unsigned samples and emits them largest-first on a valid/ready output stream. It is the read-out counterpart to the running max/second-max tracker: the tracker absorbs a stream and keeps only its top two values, while this block re-emits a whole burst in descending order. Downstream logic can therefore consume rank-ordered data, with the first beat equal to the burst maximum and the second equal to the burst second-largest.

## Interface
- DATA_WIDTH, 32: sample width; all comparisons unsigned.
- DEPTH, 4: maximum samples per burst; legal range 2..16.

- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_WIDTH  input sample.
- in_last  in  1  marks final sample of a burst.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_WIDTH  current largest remaining sample.
- out_last  out  1  marks final output beat of a burst.
- count  out  $clog2(DEPTH+1)  number of samples currently held.

## Operation
- Storage: DEPTH slots e[0..DEPTH-1], always sorted descending over the first `count` entries. Unused slots hold 0.
- FSM states:
  - FILL: in_ready=1, out_valid=0.
  - DRAIN: in_ready=0, out_valid=1.
  - Reset state is FILL.
- FILL accept (in_valid & in_ready): insert in_data at position p, where p is the number of held entries >= in_data. Entries at p and above shift down one slot. count += 1.
  - Ties: the new sample goes after existing equal values.
- FILL → DRAIN when the accepted beat has in_last=1, or when the accept brings count to DEPTH. A full buffer forces end-of-burst; in_last on that beat is ignored either way.
- DRAIN outputs:
  - out_data = e[0].
  - out_last = (count==1).
- DRAIN handshake (out_valid & out_ready): shift e[i] ← e[i+1] for all i, e[DEPTH-1] ← 0, count -= 1.
- DRAIN → FILL on the handshake where out_last=1. count is 0 at that point.
- out_valid must not drop while waiting for out_ready. out_data and out_last hold stable under backpressure.
- Reset (resetn=0) takes priority over everything, mid-fill or mid-drain:
  - all slots cleared to 0, count=0, state=FILL.
  - Any partial burst is discarded and no out_last is emitted.
- Reset values: in_ready=0 while resetn=0, then 1 on the first cycle after release. out_valid=0, out_data=0, out_last=0, count=0.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Timing
- Accepted sample is visible in e[] and count on the next cycle.
- Burst latency: last input accepted at edge t → out_valid=1 in cycle t+1, with out_data = burst maximum.
- Throughput: 1 sample/cycle in; 1 beat/cycle out when out_ready=1.
- Turnaround: the final out_last handshake at edge t → in_ready=1 in cycle t+1. There is no overlap between FILL and DRAIN.
- A burst of N samples takes N input cycles + N output cycles, minimum.

## Test plan
- Reset then burst 5,9,2,7 (last on 7), out_ready=1 → out_data 9,7,5,2; out_last only on 2; in_ready=1 the cycle after.
- DEPTH=4, send 3,1,4,1 with in_last=0 throughout → forced DRAIN after the 4th beat; outputs 4,3,1,1; in_ready=0 during drain.
- Duplicates and extremes: 0, FFFFFFFF, 0, FFFFFFFF (last) → FFFFFFFF, FFFFFFFF, 0, 0; first two beats match the tracker's max and second-max.
- Backpressure: burst 10,20 (last), out_ready low for 3 cycles → out_valid held; out_data=20 stable; then 20, 10 with out_last on 10.
- Single-sample burst: 42 with in_last=1 → one beat 42 with out_last=1, count returns to 0.
- resetn=0 in the middle of a drain (after beat 9 of 9,7,5) → next cycle out_valid=0, count=0; after release, a new burst 1,2 (last) emits 2,1.
